// File: rtl/burst_ram_arbiter.sv
// -----------------------------------------------------------------------------
// burst_ram_arbiter
//
// Purpose
//   Lets two burst-style clients share one BurstRAM, for example an
//   instruction cache on client 0 and a data cache on client 1. Each client
//   port looks like the BurstRAM command interface. Grants are round-robin,
//   and each grant is held for one complete burst. A request is accepted in
//   the same cycle it is presented (zero added latency), as long as the
//   BurstRAM is not busy.
//
// Configuration
//   BURST_ARB_FIXED_PRIORITY_EN : when defined, client 0 always wins a tie.
//                                 last_grant is still tracked but has no
//                                 effect on the result. When undefined, a
//                                 tie goes to the client that was not
//                                 granted last (round-robin).
//
// Parameters
//   DEPTH_BITWIDTH : width of the burst address (8-byte words)
//   BURST_COUNT    : 64-bit beats per burst for reads and writes (>= 1)
//
// Ports
//   sys_clk, sys_rst_n     : clock; asynchronous active-low reset
//   cX_cmd                 : client X command, 0 = read, 1 = write
//   cX_cmd_en              : client X request; the client holds it with
//                            cmd/addr/wr_data until it is accepted
//   cX_addr                : client X burst address
//   cX_wr_data             : client X write beat
//   cX_data_mask           : client X byte mask, passed through to the BurstRAM
//   cX_rd_data             : read data (the same bus goes to both clients)
//   cX_rd_data_ready       : read beat valid for client X
//   cX_busy                : client X request is not accepted this cycle
//   br_cmd, br_cmd_en      : command and command strobe to the BurstRAM
//   br_addr, br_wr_data    : address and write beat to the BurstRAM
//   br_data_mask           : byte mask to the BurstRAM
//   br_rd_data             : read beat from the BurstRAM
//   br_rd_data_ready       : read beat valid from the BurstRAM
//   br_busy                : BurstRAM cannot take a command this cycle
// -----------------------------------------------------------------------------
module burst_ram_arbiter #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,

    input  logic                      c0_cmd,
    input  logic                      c0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] c0_addr,
    input  logic [63:0]               c0_wr_data,
    input  logic [7:0]                c0_data_mask,
    output logic [63:0]               c0_rd_data,
    output logic                      c0_rd_data_ready,
    output logic                      c0_busy,

    input  logic                      c1_cmd,
    input  logic                      c1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] c1_addr,
    input  logic [63:0]               c1_wr_data,
    input  logic [7:0]                c1_data_mask,
    output logic [63:0]               c1_rd_data,
    output logic                      c1_rd_data_ready,
    output logic                      c1_busy,

    output logic                      br_cmd,
    output logic                      br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]               br_wr_data,
    output logic [7:0]                br_data_mask,
    input  logic [63:0]               br_rd_data,
    input  logic                      br_rd_data_ready,
    input  logic                      br_busy
);

    localparam int CW = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0] CNT_WRITE = CW'(BURST_COUNT - 1);
    localparam logic [CW-1:0] CNT_READ  = CW'(BURST_COUNT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Client inputs gathered into arrays so the mux and the per-client
    // outputs can be written once, indexed by client number.
    logic [1:0]                      cl_req;
    logic [1:0]                      cl_cmd;
    logic [DEPTH_BITWIDTH-1:0]       cl_addr [2];
    logic [63:0]                     cl_wr_data [2];
    logic [7:0]                      cl_mask [2];
    logic [1:0]                      busy_vec;
    logic [1:0]                      rdy_vec;

    assign cl_req        = {c1_cmd_en, c0_cmd_en};
    assign cl_cmd        = {c1_cmd, c0_cmd};
    assign cl_addr[0]    = c0_addr;
    assign cl_addr[1]    = c1_addr;
    assign cl_wr_data[0] = c0_wr_data;
    assign cl_wr_data[1] = c1_wr_data;
    assign cl_mask[0]    = c0_data_mask;
    assign cl_mask[1]    = c1_data_mask;

    // -------------------------------------------------------------------------
    // Arbitration (only meaningful while idle)
    // -------------------------------------------------------------------------
    logic [1:0] eligible;
    logic       grant_any;
    logic       tie_winner;
    logic       winner;
    logic       accept;
    logic       sel;

    // A request can only be taken while the BurstRAM is ready for a command.
    assign eligible  = cl_req & {2{~br_busy}};
    assign grant_any = |eligible;

`ifdef BURST_ARB_FIXED_PRIORITY_EN
    assign tie_winner = 1'b0;
`else
    assign tie_winner = ~last_grant_q;
`endif

    // With a single eligible requester, that requester wins. When nobody is
    // eligible the value does not matter, and 0 is used.
    assign winner = (eligible == 2'b11) ? tie_winner : eligible[1];
    assign accept = (state_q == ST_IDLE) && grant_any;

    // On the accept cycle the winner drives the BurstRAM. Otherwise the
    // registered owner does. The select is always a known value, so the
    // don't-care outputs never carry X from the mux.
    assign sel = accept ? winner : owner_q;

    // -------------------------------------------------------------------------
    // BurstRAM-side outputs
    // -------------------------------------------------------------------------
    assign br_cmd       = cl_cmd[sel];
    assign br_cmd_en    = accept;
    assign br_addr      = cl_addr[sel];
    assign br_wr_data   = cl_wr_data[sel];
    assign br_data_mask = cl_mask[sel];

    // -------------------------------------------------------------------------
    // Client-side outputs
    // -------------------------------------------------------------------------
    assign c0_rd_data = br_rd_data;
    assign c1_rd_data = br_rd_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            // A client can issue a command only while the arbiter is idle,
            // the BurstRAM is free, and no other client is taking the slot.
            assign busy_vec[gi] = !((state_q == ST_IDLE) && !br_busy &&
                                    !(grant_any && (winner != 1'(gi))));
            // Read beats reach only the owner, and only during a read burst.
            // A stray beat in any other state is dropped.
            assign rdy_vec[gi]  = (state_q == ST_READ) && br_rd_data_ready &&
                                  (owner_q == 1'(gi));
        end
    endgenerate

    assign c0_busy          = busy_vec[0];
    assign c1_busy          = busy_vec[1];
    assign c0_rd_data_ready = rdy_vec[0];
    assign c1_rd_data_ready = rdy_vec[1];

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    owner_d      = winner;
                    last_grant_d = winner;
                    if (cl_cmd[winner]) begin
                        // The first write beat goes out with the command,
                        // so BURST_COUNT-1 beats remain.
                        cnt_d   = CNT_WRITE;
                        state_d = (BURST_COUNT == 1) ? ST_IDLE : ST_WRITE;
                    end else begin
                        cnt_d   = CNT_READ;
                        state_d = ST_READ;
                    end
                end
            end

            ST_WRITE: begin
                // One write beat per cycle. No handshake is needed, because the
                // owner supplies its beats back to back.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end

            ST_READ: begin
                if (br_rd_data_ready) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers. last_grant resets to 1 so client 0 takes the first tie.
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM between two burst-style requesters, e.g. an instruction cache on client 0 and a data cache on client 1.
- Each client port mirrors the BurstRAM command interface.
- Grants are round-robin, and each grant is held for one complete burst.

Parameters:
DEPTH_BITWIDTH, 4, width of burst address (8-byte words)
BURST_COUNT, 4, 64-bit beats per burst (read and write), >=1

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
c0_cmd  in  1  client 0 command, 0 read / 1 write
c0_cmd_en  in  1  client 0 request, held with cmd/addr/wr_data until accepted
c0_addr  in  DEPTH_BITWIDTH  client 0 burst address
c0_wr_data  in  64  client 0 write beat
c0_data_mask  in  8  client 0 mask, passed through
c0_rd_data  out  64  read data (shared bus)
c0_rd_data_ready  out  1  read beat valid for client 0
c0_busy  out  1  client 0 request not accepted this cycle
c1_*  same set as c0_* for client 1
br_cmd  out  1  to BurstRAM cmd
br_cmd_en  out  1  to BurstRAM cmd_en
br_addr  out  DEPTH_BITWIDTH  to BurstRAM addr
br_wr_data  out  64  to BurstRAM wr_data
br_data_mask  out  8  to BurstRAM data_mask
br_rd_data  in  64  from BurstRAM
br_rd_data_ready  in  1  from BurstRAM
br_busy  in  1  from BurstRAM

Behaviour:
- State machine: IDLE, WRITE, READ. Registers: owner (1 bit), last_grant (1 bit), beat counter of width $clog2(BURST_COUNT)+1.
- Reset values: state IDLE, owner 0, last_grant 1, counter 0. Client 0 therefore wins the first tie.
- IDLE, winner selection:
  - Candidate set is every client with cmd_en high. A request is eligible only when br_busy is low.
  - On a tie, the winner is the client != last_grant.
- IDLE, accept cycle:
  - Winner's cmd/addr/wr_data/data_mask drive br_* combinationally; br_cmd_en=1.
  - Winner busy=0. The loser, and any client while br_busy=1, sees busy=1.
  - Zero added latency.
- Registered on accept: owner and last_grant <= winner.
  - Write: counter <= BURST_COUNT-1; go to WRITE, or stay in IDLE if BURST_COUNT==1.
  - Read: counter <= BURST_COUNT; go to READ.
- WRITE:
  - br_wr_data/br_data_mask follow owner's inputs each cycle. The owner supplies beats 1..BURST_COUNT-1 on consecutive cycles after accept.
  - Counter decrements each cycle; when it reaches 0, go to IDLE.
  - br_cmd_en=0. Both busy=1.
- READ:
  - br_rd_data is broadcast to both c*_rd_data. c<owner>_rd_data_ready = br_rd_data_ready; the other client's ready is 0.
  - Counter decrements per beat. On the last beat, go to IDLE; the next arbitration happens the cycle after the last beat.
  - Both busy=1.
- Outside READ, both rd_data_ready=0 and br_cmd_en=0 except on the accept cycle.
- br_cmd/br_addr outside accept: driven from owner inputs. Values are don't-care but never X-propagating from the mux.
- Boundary cases:
  - Request dropped before accept: no effect.
  - br_busy high in IDLE: no grant, and last_grant is unchanged.
  - Single requester always wins regardless of last_grant.
  - Stray br_rd_data_ready in IDLE/WRITE: ignored, not forwarded.
- Async reset mid-burst: immediately IDLE, all outputs at reset values. Client bursts are abandoned; the BurstRAM shares the same reset.

Optional Feature:
- BURST_ARB_FIXED_PRIORITY_EN defined: client 0 always wins a tie. last_grant is still updated but is ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset, then c0 read at addr 2: accept on first cycle (br_cmd_en=1, br_addr=2, c0_busy=0). 4 beats appear only on c0_rd_data_ready; then IDLE.
- c0 and c1 both request reads in the same cycle after reset: c0 served first, then c1 on the cycle after c0's 4th beat. Repeat the tie: c0 wins again, since last_grant is now 1.
- c1 write at addr 5 with beats 0x11,0x22,0x33,0x44: br_wr_data shows these on 4 consecutive cycles. c0 request during the burst stays busy until the cycle after the final beat.
- br_busy held high with c0_cmd_en=1: no br_cmd_en, c0_busy=1. br_busy low: grant the same cycle.
- Assert sys_rst_n=0 after the 2nd read beat: state IDLE, all ready/busy-driven outputs at reset values asynchronously. The next tie goes to c0.
- With BURST_ARB_FIXED_PRIORITY_EN, three back-to-back ties: c0 granted all three; c1 granted only when c0_cmd_en=0.
